// File: rtl/bpt_gshare_pkg.sv
// Shared types, default sizes and the saturating counter helper for branch predictors.
package bpt_gshare_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {BPT_IDLE, BPT_CLEAR} bpt_state_t;

   localparam int BPT_ENTRIES  = 64;
   localparam int BPT_CTR_BITS = 2;
   localparam int BPT_HIST_LEN = 6;

   // Widest counter the shared helper handles; callers zero-extend and truncate.
   localparam int CTR_W_MAX = 16;

   // Saturating up/down step of a counter whose ceiling is max.
   function automatic logic [CTR_W_MAX-1:0] sat_update(
      input logic [CTR_W_MAX-1:0] ctr,
      input logic                 up,
      input logic [CTR_W_MAX-1:0] max
   );
      if (up) return (ctr >= max) ? ctr : ctr + 1'b1;
      else    return (ctr == '0)  ? ctr : ctr - 1'b1;
   endfunction

endpackage

// File: rtl/bpt_gshare_if.sv
// Fetch/resolution/flush bundle between the pipeline (master) and the predictor (slave).
interface bpt_gshare_if #(
   parameter int IDX_W = 6
);
   import bpt_gshare_pkg::*;

   word_t            pc_fetch;
   logic             pred_fetch;
   logic [IDX_W-1:0] idx_fetch;
   logic             enable_res;
   logic [IDX_W-1:0] idx_res;
   logic             taken_res;
   logic             flush;
   logic             busy;

   modport slave (
      input  pc_fetch, enable_res, idx_res, taken_res, flush,
      output pred_fetch, idx_fetch, busy
   );

   modport master (
      output pc_fetch, enable_res, idx_res, taken_res, flush,
      input  pred_fetch, idx_fetch, busy
   );

endinterface

// File: rtl/bpt_gshare_clear_fsm.sv
// Flush sequencer: sweeps a pointer over every table entry, one per cycle.
module bpt_gshare_clear_fsm
   import bpt_gshare_pkg::*;
#(
   parameter  int ENTRIES = BPT_ENTRIES,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             flush,
   output bpt_state_t       state,
   output logic             busy,
   output logic             clr_en,
   output logic [IDX_W-1:0] clr_idx
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

   logic [IDX_W-1:0] ptr;

   assign clr_en  = busy;
   assign clr_idx = ptr;

   // State, pointer and registered busy; flush in any state (re)starts the sweep.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= BPT_IDLE;
         ptr   <= '0;
         busy  <= 1'b0;
      end else if (flush) begin
         state <= BPT_CLEAR;
         ptr   <= '0;
         busy  <= 1'b1;
      end else if (state == BPT_CLEAR) begin
         if (ptr == LAST) begin
            state <= BPT_IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
         end else begin
            ptr <= ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/bpt_gshare.sv
// Bimodal/gshare branch prediction table with saturating counters and a flush sweep.
module bpt_gshare
   import bpt_gshare_pkg::*;
#(
   parameter  int ENTRIES  = BPT_ENTRIES,
   parameter  int CTR_BITS = BPT_CTR_BITS,
   parameter  int HIST_LEN = BPT_HIST_LEN,
   parameter  int GSHARE   = 1,
   localparam int IDX_W    = $clog2(ENTRIES)
) (
   input logic                 CLK,
   input logic                 RST,
   bpt_gshare_if.slave         bus
);

   localparam logic [CTR_BITS-1:0]  WNT     = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_W_MAX-1:0] CTR_MAX = CTR_W_MAX'((1 << CTR_BITS) - 1);

   logic [CTR_BITS-1:0] ctr [ENTRIES];
   logic [HIST_LEN-1:0] ghr;
   logic [HIST_LEN-1:0] ghr_next;
   logic [IDX_W-1:0]    base;
   logic [IDX_W-1:0]    idx;
   bpt_state_t          state;
   logic                busy;
   logic                clr_en;
   logic [IDX_W-1:0]    clr_idx;
   logic                upd;
   logic                unused_pc;

   bpt_gshare_clear_fsm #(
      .ENTRIES (ENTRIES)
   ) u_clear_fsm (
      .CLK     (CLK),
      .RST     (RST),
      .flush   (bus.flush),
      .state   (state),
      .busy    (busy),
      .clr_en  (clr_en),
      .clr_idx (clr_idx)
   );

   assign unused_pc = ^{bus.pc_fetch[31:IDX_W+2], bus.pc_fetch[1:0]};
   assign base      = bus.pc_fetch[IDX_W+1:2];

   if (GSHARE != 0) begin : g_gshare
      assign idx = base ^ IDX_W'(ghr);
   end else begin : g_bimodal
      assign idx = base;
   end

   if (HIST_LEN == 1) begin : g_hist1
      assign ghr_next = bus.taken_res;
   end else begin : g_histn
      assign ghr_next = {ghr[HIST_LEN-2:0], bus.taken_res};
   end

   assign bus.idx_fetch  = idx;
   assign bus.pred_fetch = (state == BPT_IDLE) ? ctr[idx][CTR_BITS-1] : 1'b0;
   assign bus.busy       = busy;

   // Training only in IDLE; a flush in the same cycle drops the update.
   assign upd = bus.enable_res && (state == BPT_IDLE) && !bus.flush;

   // Counter table: reset/sweep to weakly-not-taken, otherwise saturating training.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < ENTRIES; i++) ctr[i] <= WNT;
      end else if (clr_en) begin
         ctr[clr_idx] <= WNT;
      end else if (upd) begin
         ctr[bus.idx_res] <= CTR_BITS'(sat_update(CTR_W_MAX'(ctr[bus.idx_res]),
                                                  bus.taken_res, CTR_MAX));
      end
   end

   // Non-speculative global history, shifted at resolution and zeroed by flush.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)            ghr <= '0;
      else if (bus.flush) ghr <= '0;
      else if (upd)       ghr <= ghr_next;
   end

endmodule

// File: tb/tb_bpt_gshare.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor checks them.
module tb_bpt_gshare;

  localparam int IDX_W = 6;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  bpt_gshare_if #(.IDX_W(IDX_W)) bi ();
  bpt_gshare_if #(.IDX_W(IDX_W)) gi ();

  bpt_gshare #(.ENTRIES(64), .CTR_BITS(2), .HIST_LEN(6), .GSHARE(0)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (bi)
  );

  bpt_gshare #(.ENTRIES(64), .CTR_BITS(2), .HIST_LEN(6), .GSHARE(1)) dut_g (
    .CLK (CLK),
    .RST (RST),
    .bus (gi)
  );

  // kind: 0 = pred_fetch, 1 = idx_fetch, 2 = busy; sel: 0 = bimodal, 1 = gshare
  typedef struct {
    string name;
    int    sel;
    int    kind;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic want(input string name, input int sel, input int kind, input int val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  function automatic int observe(input int sel, input int kind);
    if (sel == 0) begin
      case (kind)
        0:       return int'(bi.pred_fetch);
        1:       return int'(bi.idx_fetch);
        default: return int'(bi.busy);
      endcase
    end else begin
      case (kind)
        0:       return int'(gi.pred_fetch);
        1:       return int'(gi.idx_fetch);
        default: return int'(gi.busy);
      endcase
    end
  endfunction

  // Monitor: outputs are stable mid-cycle, so drain pending expectations at negedge.
  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      exp_t e;
      int   act;
      e   = sb.pop_front();
      act = observe(e.sel, e.kind);
      checks++;
      if (act != e.val) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input string name, input int sel, input int unsigned max_cycles);
    int unsigned n;
    n = 0;
    while (observe(sel, 2) != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (observe(sel, 2) != 0) begin
      errors++;
      $display("FAIL %s: busy still high after %0d cycles", name, max_cycles);
    end
  endtask

  task automatic set_pc(input int sel, input logic [31:0] pc);
    if (sel == 0) bi.pc_fetch = pc;
    else          gi.pc_fetch = pc;
  endtask

  task automatic set_flush(input int sel, input logic f);
    if (sel == 0) bi.flush = f;
    else          gi.flush = f;
  endtask

  task automatic drive_res(input int sel, input logic en, input int idx, input logic tk);
    if (sel == 0) begin
      bi.enable_res = en;
      bi.idx_res    = IDX_W'(idx);
      bi.taken_res  = tk;
    end else begin
      gi.enable_res = en;
      gi.idx_res    = IDX_W'(idx);
      gi.taken_res  = tk;
    end
  endtask

  task automatic resolve(input int sel, input int idx, input logic tk);
    drive_res(sel, 1'b1, idx, tk);
    tick();
    drive_res(sel, 1'b0, 0, 1'b0);
  endtask

  initial begin
    bi.pc_fetch = '0; bi.enable_res = 1'b0; bi.idx_res = '0; bi.taken_res = 1'b0; bi.flush = 1'b0;
    gi.pc_fetch = '0; gi.enable_res = 1'b0; gi.idx_res = '0; gi.taken_res = 1'b0; gi.flush = 1'b0;

    // Reset state
    tick();
    checks++;
    if (bi.busy !== 1'b0 || gi.busy !== 1'b0 || bi.pred_fetch !== 1'b0 ||
        gi.pred_fetch !== 1'b0 || bi.idx_fetch !== '0 || gi.idx_fetch !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b/%b pred=%b/%b idx=%0d/%0d",
               bi.busy, gi.busy, bi.pred_fetch, gi.pred_fetch, bi.idx_fetch, gi.idx_fetch);
    end
    want("rst_busy_b", 0, 2, 0);
    want("rst_busy_g", 1, 2, 0);
    want("rst_pred_b", 0, 0, 0);
    want("rst_idx_g_pc0", 1, 1, 0);
    tick();
    RST = 1'b0;

    for (int unsigned i = 0; i < 64; i++) begin
      set_pc(0, 32'(i * 4));
      want("rst_read_idx", 0, 1, i);
      want("rst_read_pred", 0, 0, 0);
      tick();
    end
    set_pc(0, 32'h104);
    set_pc(1, 32'h104);
    want("bimodal_idx_0x104", 0, 1, 1);
    want("gshare_idx_0x104_ghr0", 1, 1, 1);
    tick();

    // Bimodal saturation at the top and bottom of idx 5
    for (int unsigned i = 0; i < 4; i++) resolve(0, 5, 1'b1);
    set_pc(0, 32'h14);
    want("sat_hi_idx", 0, 1, 5);
    want("sat_hi_pred", 0, 0, 1);
    resolve(0, 5, 1'b0);
    want("ctr2_pred", 0, 0, 1);
    resolve(0, 5, 1'b0);
    want("ctr1_pred", 0, 0, 0);
    resolve(0, 5, 1'b0);
    resolve(0, 5, 1'b0);
    resolve(0, 5, 1'b1);
    want("sat_lo_then_1_pred", 0, 0, 0);
    resolve(0, 5, 1'b1);
    want("sat_lo_then_2_pred", 0, 0, 1);

    // Gshare history: T, T, N -> GHR = 6; ctr[10]: 1,2,3,2
    resolve(1, 10, 1'b1);
    resolve(1, 10, 1'b1);
    resolve(1, 10, 1'b0);
    set_pc(1, 32'h0);
    want("ghr_idx_pc0", 1, 1, 6);
    tick();
    set_pc(1, 32'h18);
    want("ghr_idx_pc18", 1, 1, 0);
    tick();
    set_pc(1, 32'h30);
    want("ghr_idx_pc30", 1, 1, 10);
    want("ghr_pred_idx10", 1, 0, 1);
    tick();

    // Same-cycle read/write of idx 3: no bypass
    set_pc(0, 32'h0C);
    drive_res(0, 1'b1, 3, 1'b1);
    want("same_cycle_pre", 0, 0, 0);
    tick();
    drive_res(0, 1'b0, 0, 1'b0);
    want("same_cycle_post", 0, 0, 1);
    tick();

    // Gshare: train idx 7 (GHR 6 -> 13 -> 27), then flush sweep with ignored updates
    resolve(1, 7, 1'b1);
    resolve(1, 7, 1'b1);
    set_pc(1, 32'h70);
    want("pre_flush_idx", 1, 1, 7);
    want("pre_flush_pred", 1, 0, 1);
    set_flush(1, 1'b1);
    tick();
    set_flush(1, 1'b0);
    for (int unsigned k = 0; k < 64; k++) begin
      want("sweep_busy", 1, 2, 1);
      want("sweep_pred", 1, 0, 0);
      drive_res(1, (k >= 10 && k < 20), 7, 1'b1);
      tick();
    end
    drive_res(1, 1'b0, 0, 1'b0);
    want("sweep_end_busy", 1, 2, 0);
    wait_idle("sweep_wait_idle", 1, 4);
    set_pc(1, 32'h1C);
    want("post_flush_ghr0_idx", 1, 1, 7);
    want("post_flush_wnt_pred", 1, 0, 0);
    tick();
    resolve(1, 7, 1'b1);
    set_pc(1, 32'h18);
    want("post_flush_ghr1_idx", 1, 1, 7);
    want("post_flush_wnt_plus1", 1, 0, 1);
    tick();

    // Flush restart in the 30th sweep cycle: 30 + 64 busy cycles
    set_flush(1, 1'b1);
    tick();
    set_flush(1, 1'b0);
    for (int unsigned k = 0; k < 94; k++) begin
      want("restart_busy", 1, 2, 1);
      set_flush(1, k == 29);
      tick();
    end
    set_flush(1, 1'b0);
    want("restart_end_busy", 1, 2, 0);
    wait_idle("restart_wait_idle", 1, 4);
    tick();

    // Asynchronous reset in the middle of a bimodal sweep
    resolve(0, 40, 1'b1);
    resolve(0, 40, 1'b1);
    set_pc(0, 32'hA0);
    want("pre_rst_pred40", 0, 0, 1);
    set_flush(0, 1'b1);
    tick();
    set_flush(0, 1'b0);
    for (int unsigned k = 0; k < 10; k++) begin
      want("rst_sweep_busy", 0, 2, 1);
      tick();
    end
    RST = 1'b1;
    want("async_rst_busy", 0, 2, 0);
    want("async_rst_pred", 0, 0, 0);
    tick();
    RST = 1'b0;
    want("post_rst_busy", 0, 2, 0);
    want("post_rst_idx40", 0, 1, 40);
    want("post_rst_pred40", 0, 0, 0);
    set_pc(1, 32'h1C);
    want("post_rst_ghr0_idx", 1, 1, 7);
    tick();
    resolve(0, 40, 1'b1);
    want("post_rst_wnt_plus1", 0, 0, 1);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bpt_gshare.md
Name: bpt_gshare

Overview:
- Parametrised successor to the single-table branch prediction table, sitting between fetch and branch resolution.
- Holds ENTRIES saturating counters of CTR_BITS each, indexed either bimodally (PC only) or gshare (PC XOR global history).
- Fetch reads a prediction combinationally and receives the index it used; resolution returns that index to train the same entry.
- A flush FSM re-initialises the table on request.

Parameters:
- ENTRIES, 64, number of counters; power of two, minimum 4. IDX_W = $clog2(ENTRIES).
- CTR_BITS, 2, counter width; minimum 1. WNT = 2^(CTR_BITS-1)-1 is the weakly-not-taken init value.
- HIST_LEN, 6, global history register (GHR) length; must be <= IDX_W.
- GSHARE, 1, indexing mode: 1 = gshare, 0 = bimodal (GHR still maintained, not used).

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- pc_fetch  in  32 (word_t)  fetch PC
- pred_fetch  out  1  1 = predict taken
- idx_fetch  out  IDX_W  table index used for pred_fetch; carried down the pipeline
- enable_res  in  1  resolution update strobe
- idx_res  in  IDX_W  index returned from fetch for the resolving branch
- taken_res  in  1  resolved direction
- flush  in  1  one-cycle request to clear table and GHR
- busy  out  1  high while the clear sweep runs

Behaviour:
- One clock, CLK. Reset is asynchronous and active-high on RST.
- Reset values:
  - all counters = WNT; GHR = 0; FSM = IDLE; sweep pointer = 0.
  - outputs: busy = 0; pred_fetch = 0; idx_fetch follows pc_fetch (0 when pc_fetch = 0).
- Index, combinational: base = pc_fetch[IDX_W+1:2].
  - GSHARE = 1: idx_fetch = base XOR {zero-extend GHR to IDX_W}.
  - GSHARE = 0: idx_fetch = base.
- Prediction, zero latency: pred_fetch = MSB of ctr[idx_fetch] when FSM = IDLE, else 0.
- Update (IDLE only): on the rising edge with enable_res = 1:
  - taken_res = 1: ctr[idx_res] increments, saturating at 2^CTR_BITS-1.
  - taken_res = 0: ctr[idx_res] decrements, saturating at 0.
  - GHR <= {GHR[HIST_LEN-2:0], taken_res}. GHR is non-speculative, updated at resolution only.
  - For HIST_LEN = 1: GHR <= taken_res.
- Same-cycle read and write of the same index: pred_fetch shows the pre-update value; there is no bypass.
- FSM has two states, IDLE and CLEAR.
  - IDLE -> CLEAR on flush = 1. On that edge: GHR <= 0, pointer <= 0.
  - In CLEAR: busy = 1; each cycle ctr[pointer] <= WNT and pointer increments.
  - CLEAR -> IDLE on the edge where pointer = ENTRIES-1 is written. The sweep therefore lasts exactly ENTRIES cycles; busy drops the following cycle.
  - enable_res during CLEAR is ignored: no counter or GHR change.
  - flush during CLEAR restarts the sweep: pointer <= 0, GHR <= 0.
  - flush and enable_res in the same IDLE cycle: flush wins and the update is dropped.
- RST asserted mid-sweep immediately forces all reset values; no partial sweep state survives.
- Pointer wrap is never reached: the FSM exits at ENTRIES-1.

Decomposition:
- datapath_pkg gains:
  - bpt_state_t enum {BPT_IDLE, BPT_CLEAR}.
  - Default constants BPT_ENTRIES = 64, BPT_CTR_BITS = 2, BPT_HIST_LEN = 6.
  - A saturating counter-update function, shared with the future BTB.
- bpt_if is extended with idx_fetch, idx_res, flush and busy, with matching bpt/tb modports.
- One sub-module is natural: bpt_clear_fsm, holding state, pointer and busy, and emitting a clear strobe and clear index.

Test Plan:
- Reset then read every index -> pred_fetch = 0, busy = 0; GSHARE = 0, pc_fetch = 0x104 -> idx_fetch = 1.
- GSHARE = 0, 4 x (enable_res = 1, idx_res = 5, taken_res = 1) -> counter saturates at 3 and pred_fetch = 1 for pc_fetch = 0x14. Then 2 x not-taken -> counter = 1, pred_fetch = 0.
- GSHARE = 1, resolve taken, taken, not-taken -> GHR = 0b000110; pc_fetch = 0x0 gives idx_fetch = 6, pc_fetch = 0x18 gives idx_fetch = 0.
- Same-cycle enable_res = 1 (idx 3, taken) with a fetch reading idx 3 at WNT -> pred_fetch = 0 that cycle, 1 the next cycle.
- Train idx 7 to 3, pulse flush -> busy high exactly 64 cycles. enable_res during the sweep is ignored; afterwards idx 7 = WNT and GHR = 0. flush at sweep cycle 30 -> busy lasts 30 + 64 cycles total.
- RST asserted at sweep cycle 10 -> busy = 0 asynchronously; all counters = WNT after release.
